// File: rtl/mem_1r1w_param.sv
// Parametrised 1R1W memory with post-reset zero sweep, masked writes and write-first reads.
// Read latency 1 (or 2 with OUT_REG); no backpressure, requests while not ready are dropped.
module mem_1r1w_param #(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 16,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int MW = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             ready,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [MW-1:0]    W0_mask
);

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  typedef struct packed {
    logic          vld;
    logic          inr;
    logic [AW-1:0] addr;
  } rd_req_t;

  logic             ready_q;
  logic [AW-1:0]    init_cnt;
  logic             sweep_we;
  logic             wr_acc;
  rd_req_t          rq;
  logic             d1_vld;
  logic [WIDTH-1:0] d1_dat;
  logic [WIDTH-1:0] mem [DEPTH];

  assign ready = ready_q;

  // reset_n gating keeps the array untouched while reset is held
  assign sweep_we = (INIT_ZERO != 0) && !ready_q && reset_n;
  assign wr_acc   = ready_q && W0_en && ({1'b0, W0_addr} <= LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      init_cnt <= '0;
    end else if (!ready_q) begin
      if (INIT_ZERO == 0 || {1'b0, init_cnt} == LAST) begin
        ready_q <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[init_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < MW; i++) begin
        if (W0_mask[i]) begin
          mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // The array is read one cycle after acceptance, so a same-cycle write has
  // already landed (write-first) while a write on the next edge is not yet seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rq     <= '0;
      d1_vld <= 1'b0;
      d1_dat <= '0;
    end else begin
      rq.vld  <= ready_q && R0_en;
      rq.inr  <= ({1'b0, R0_addr} <= LAST);
      rq.addr <= R0_addr;
      d1_vld  <= rq.vld;
      if (rq.vld) begin
        d1_dat <= rq.inr ? mem[rq.addr] : '0;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic             d2_vld;
    logic [WIDTH-1:0] d2_dat;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        d2_vld <= 1'b0;
        d2_dat <= '0;
      end else begin
        d2_vld <= d1_vld;
        if (d1_vld) begin
          d2_dat <= d1_dat;
        end
      end
    end

    assign R0_valid = d2_vld;
    assign R0_data  = d2_dat;
  end else begin : g_noreg
    assign R0_valid = d1_vld;
    assign R0_data  = d1_dat;
  end

endmodule

// File: tb/tb_mem_1r1w_param.sv
// Directed bench: DEPTH=32/OUT_REG=0 and DEPTH=24/OUT_REG=1 instances share all inputs.
module tb_mem_1r1w_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  r_addr, w_addr;
  logic        r_en, w_en;
  logic [63:0] w_data;
  logic [3:0]  w_mask;
  logic [63:0] a_data, b_data;
  logic        a_vld, b_vld, a_rdy, b_rdy;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  mem_1r1w_param #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(16), .OUT_REG(0), .INIT_ZERO(1)) u_a (
    .clock(clock), .reset_n(reset_n), .ready(a_rdy),
    .R0_addr(r_addr), .R0_en(r_en), .R0_data(a_data), .R0_valid(a_vld),
    .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask)
  );

  mem_1r1w_param #(.DEPTH(24), .WIDTH(64), .MASK_GRAN(16), .OUT_REG(1), .INIT_ZERO(1)) u_b (
    .clock(clock), .reset_n(reset_n), .ready(b_rdy),
    .R0_addr(r_addr), .R0_en(r_en), .R0_data(b_data), .R0_valid(b_vld),
    .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    r_en = 1'b0; w_en = 1'b0; r_addr = '0; w_addr = '0; w_data = '0; w_mask = '0;
  endtask

  task automatic req(input logic [4:0] a, input logic [63:0] d);
    r_en = 1'b1; w_en = 1'b1; r_addr = a; w_addr = a; w_data = d; w_mask = 4'hF;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [3:0] m);
    w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
    @(negedge clock);
    idle();
  endtask

  // single read (optionally with a same-address write), checks latency and hold on both instances
  task automatic xfer(input string tag, input logic [4:0] ra, input logic [63:0] ea, input logic [63:0] eb,
                      input logic we, input logic [63:0] wd, input logic [3:0] wm);
    r_en = 1'b1; r_addr = ra; w_en = we; w_addr = ra; w_data = wd; w_mask = wm;
    @(negedge clock);
    idle();
    check({tag, "_a_early"}, a_vld, 0);
    @(negedge clock);
    check({tag, "_a_vld"}, a_vld, 1);
    check({tag, "_a_dat"}, a_data, ea);
    check({tag, "_b_early"}, b_vld, 0);
    @(negedge clock);
    check({tag, "_a_drop"}, a_vld, 0);
    check({tag, "_b_vld"}, b_vld, 1);
    check({tag, "_b_dat"}, b_data, eb);
    @(negedge clock);
    check({tag, "_b_drop"}, b_vld, 0);
    check({tag, "_a_hold"}, a_data, ea);
  endtask

  // 32 back-to-back reads of addresses 0..31; ident selects data==addr versus all-zero contents
  task automatic stream(input bit ident);
    for (int c = 0; c < 35; c++) begin
      if (c >= 2 && c < 34) begin
        check("stream_a_vld", a_vld, 1);
        check("stream_a_dat", a_data, ident ? 64'(c - 2) : 64'd0);
      end else begin
        check("stream_a_idle", a_vld, 0);
      end
      if (c >= 3) begin
        check("stream_b_vld", b_vld, 1);
        check("stream_b_dat", b_data, (ident && (c - 3) < 24) ? 64'(c - 3) : 64'd0);
      end else begin
        check("stream_b_idle", b_vld, 0);
      end
      if (c < 32) begin
        r_en = 1'b1; r_addr = c[4:0];
      end else begin
        idle();
      end
      @(negedge clock);
    end
    for (int c = 0; c < 3; c++) begin
      check("hold_a_vld", a_vld, 0);
      check("hold_a_dat", a_data, ident ? 64'd31 : 64'd0);
      check("hold_b_vld", b_vld, 0);
      check("hold_b_dat", b_data, 64'd0);
      @(negedge clock);
    end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      req(5'd3, '1);
      check("rst_a_rdy", a_rdy, 0);
      check("rst_a_vld", a_vld, 0);
      check("rst_a_dat", a_data, 0);
      check("rst_b_vld", b_vld, 0);
      check("rst_b_dat", b_data, 0);
    end
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k <= 20) req(5'd3, '1);
      else idle();
      @(negedge clock);
      check("init_a_rdy", a_rdy, (k >= 32) ? 64'd1 : 64'd0);
      check("init_b_rdy", b_rdy, (k >= 24) ? 64'd1 : 64'd0);
      check("init_a_vld", a_vld, 0);
      check("init_b_vld", b_vld, 0);
    end
    idle();

    stream(1'b0);

    for (int i = 0; i < 32; i++) begin
      w_en = 1'b1; w_addr = 5'(i); w_data = 64'(i); w_mask = 4'hF;
      @(negedge clock);
    end
    idle();
    stream(1'b1);

    wr(5'd5, '1, 4'hF);
    wr(5'd5, 64'h1111_2222_3333_4444, 4'b0101);
    wr(5'd5, 64'h0, 4'b0000);
    xfer("mask", 5'd5, 64'hFFFF_2222_FFFF_4444, 64'hFFFF_2222_FFFF_4444, 1'b0, '0, '0);

    wr(5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 4'hF);
    xfer("coll", 5'd7, 64'h5555_AAAA_AAAA_AAAA, 64'h5555_AAAA_AAAA_AAAA,
         1'b1, 64'h5555_5555_5555_5555, 4'b1000);
    xfer("coll_next", 5'd7, 64'h5555_AAAA_AAAA_AAAA, 64'h5555_AAAA_AAAA_AAAA, 1'b0, '0, '0);

    // reset while a read is in flight
    r_en = 1'b1; r_addr = 5'd5;
    @(negedge clock);
    idle();
    reset_n = 1'b0;
    #1;
    check("flight_a_vld", a_vld, 0);
    check("flight_a_dat", a_data, 0);
    check("flight_a_rdy", a_rdy, 0);
    check("flight_b_dat", b_data, 0);
    @(negedge clock);
    check("flight_a_late", a_vld, 0);
    check("flight_b_late", b_vld, 0);
    reset_n = 1'b1;

    for (int k = 1; k <= 10; k++) begin
      req(5'd5, 64'h1234);
      @(negedge clock);
      check("sweep1_a_rdy", a_rdy, 0);
      check("sweep1_a_vld", a_vld, 0);
    end
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 32) req(5'd5, 64'h1234);
      else idle();
      @(negedge clock);
      check("sweep2_a_rdy", a_rdy, (k >= 32) ? 64'd1 : 64'd0);
      check("sweep2_b_rdy", b_rdy, (k >= 24) ? 64'd1 : 64'd0);
      check("sweep2_a_vld", a_vld, 0);
    end
    idle();
    xfer("post_rst5", 5'd5, 64'h0, 64'h1234, 1'b0, '0, '0);
    xfer("post_rst7", 5'd7, 64'h0, 64'h0, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_param.md
# mem_1r1w_param

Parametrised single-clock 1-read/1-write memory. It supersedes the fixed 32x64 one-read/one-write wrapper. It adds:
- configurable depth, width and write-mask granularity
- a self-clearing init sequencer after reset
- write-first collision bypass
- optional output pipeline register with a read-valid strobe

It sits behind Chisel-lowered `SyncReadMem` instances wherever a 1R1W array needs deterministic post-reset contents.

## Interface
Parameters:
- DEPTH, 32, number of words; any value ≥2 (not restricted to powers of two)
- WIDTH, 64, bits per word
- MASK_GRAN, 16, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN; MASK_GRAN = WIDTH gives an unmasked memory
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
- INIT_ZERO, 1, 1 clears every word to 0 after reset; 0 skips the sweep and leaves contents undefined

Derived: AW = max(1, clog2(DEPTH)); MW = WIDTH/MASK_GRAN.

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ready  out  1  high when the init sweep is finished and ports are accepted
- R0_addr  in  AW  read address
- R0_en  in  1  read enable, active-high
- R0_data  out  WIDTH  read data
- R0_valid  out  1  one-cycle strobe marking R0_data as updated by a read
- W0_addr  in  AW  write address
- W0_en  in  1  write enable, active-high
- W0_data  in  WIDTH  write data
- W0_mask  in  MW  per-lane write enable; bit i covers W0_data[i*MASK_GRAN +: MASK_GRAN]

## Operation
- Reset (reset_n low), asynchronous:
  - ready=0, R0_valid=0, R0_data=0, pipeline registers cleared, init counter=0
  - array contents are not touched by reset itself
- Init sweep (INIT_ZERO=1):
  - starts on the first rising edge after reset_n rises
  - writes 0 to address k on edge k+1, for k = 0..DEPTH-1
  - ready=0 throughout; R0_en and W0_en are ignored
  - reset asserted mid-sweep restarts the sweep from address 0
- INIT_ZERO=0: ready rises on the first edge after reset release.
- A read is accepted when ready & R0_en. A write is accepted when ready & W0_en.
- Write: for each mask bit set, the corresponding lane of word W0_addr is updated; lanes with mask bit 0 keep their value. W0_en with W0_mask=0 changes nothing.
- Out-of-range addresses (≥ DEPTH):
  - writes are dropped
  - reads complete normally, with R0_valid, and return all zeros
- Collision (accepted read and write, same in-range address, same cycle) is write-first:
  - lanes with mask bit 1 return the new W0_data
  - other lanes return the pre-write contents
- R0_data holds its last value when no read completes. It never changes without R0_valid.
- Reads and writes are fully pipelined: one of each per cycle, no backpressure.

## Timing
- OUT_REG=0: read accepted at edge N → R0_data/R0_valid valid after edge N+1, R0_valid high for that cycle only.
- OUT_REG=1: same, at edge N+2.
- Back-to-back reads give R0_valid high on consecutive cycles with matching data order.
- Write accepted at edge N is visible to a read accepted at edge N (bypass) and to any later read.
- ready rises after edge DEPTH from reset release (INIT_ZERO=1), or after edge 1 (INIT_ZERO=0). It then stays high until the next reset.
- Requests presented while ready=0 are dropped, not queued. R0_valid never rises for them.
- Reset asserted with reads in flight: in-flight results are discarded, and R0_valid stays 0 until a new post-ready read completes.

## Test plan
- Reset/init, DEPTH=32, INIT_ZERO=1:
  - release reset → ready=0 for 32 cycles, then 1
  - read of each address 0..31 → 0 with R0_valid
  - R0_data=0 and R0_valid=0 throughout reset
- Masked write, WIDTH=64, MASK_GRAN=16:
  - write 0xFFFF_FFFF_FFFF_FFFF to addr 5 with mask 0xF
  - then write 0x1111_2222_3333_4444 with mask 0b0101
  - read addr 5 → 0xFFFF_2222_FFFF_4444, latency 1 (OUT_REG=0) or 2 (OUT_REG=1)
- Collision:
  - addr 7 holds 0xAAAA_AAAA_AAAA_AAAA
  - same-cycle write 0x5555_5555_5555_5555 with mask 0b1000, plus read of addr 7
  - read → 0x5555_AAAA_AAAA_AAAA; a next-cycle read returns the same value
- Streaming:
  - 32 back-to-back reads of addr i, where addr i holds i
  - R0_valid high 32 consecutive cycles, R0_data = 0..31 in order
  - idle cycles hold R0_data=31
- Non-power-of-two, DEPTH=24:
  - write to addr 30 is dropped
  - read addr 30 → 0 with R0_valid
  - addr 23 reads back correctly
- Mid-sweep reset:
  - assert reset_n low at sweep cycle 10, requests presented during the sweep
  - sweep restarts, ready rises 32 cycles after the new release
  - R0_valid never fires for requests made while ready=0
